// File: rtl/branch_resolve_ctrl_pkg.sv
// rtl/branch_resolve_ctrl_pkg.sv - shared types and constants for the branch resolve controller
//
// Holds the resolve FSM state encoding, the BTB update entry layout
// ({pc, target, taken}, 65 bits) and the sequential-PC helper.
package branch_resolve_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int UPD_W = 2 * XLEN + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } brc_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
    } upd_entry_t;

    // Fall-through address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] fallthrough_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_fifo.sv
// rtl/branch_resolve_ctrl_fifo.sv - btb_update_fifo: queue of pending BTB updates
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write side; push is ignored when full
//   full                no free entry
//   out_valid/out_ready head handshake; out_data is the head entry (zero when empty)
module btb_update_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign do_push   = push & ~full;
    assign do_pop    = out_valid & out_ready;

    // Storage is not reset; the head is masked so stale data never leaks out.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - resolves EX-stage branches: redirect, flush, BTB update queue, stats
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   ex_valid, ex_is_branch, ex_pc    EX instruction qualifiers and PC
//   ex_taken, ex_target              resolved outcome and target
//   ex_pred_taken, ex_pred_target    fetch-time prediction
//   ex_stall                         EX must hold (update queue full)
//   redirect_valid, redirect_pc      one-cycle fetch redirect after a mispredict
//   flush                            kill wrong-path IF/ID contents
//   upd_valid/upd_ready, upd_pc,
//   upd_target, upd_taken            BTB update stream
//   stat_branches, stat_mispredicts  saturating statistics counters
import branch_resolve_ctrl_pkg::*;

module branch_resolve_ctrl #(
    parameter int FIFO_DEPTH   = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             ex_stall,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target,
    output logic             upd_taken,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    brc_state_t  state;
    brc_state_t  state_next;
    logic [FC_W-1:0] flush_cnt;
    logic        flush_last;
    logic        q_full;
    logic        br_seen;
    logic        accepted;
    logic        mispredict;
    logic [31:0] correct_pc;
    upd_entry_t  enq_entry;
    upd_entry_t  head_entry;

    // A branch in IDLE either proceeds or stalls; in FLUSH it is wrong-path and dropped.
    assign br_seen    = ex_valid & ex_is_branch & (state == ST_IDLE);
    assign accepted   = br_seen & ~q_full;
    assign ex_stall   = br_seen & q_full;
    assign mispredict = accepted & ((ex_taken != ex_pred_taken) |
                                    (ex_taken & (ex_pred_target != ex_target)));
    assign correct_pc = ex_taken ? ex_target : fallthrough_pc(ex_pc);
    assign flush_last = (flush_cnt == FC_W'(FLUSH_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= (state == ST_FLUSH && state_next == ST_FLUSH) ?
                         flush_cnt + FC_W'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (mispredict) state_next = ST_FLUSH;
            ST_FLUSH: if (flush_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        flush = (state == ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            redirect_valid <= mispredict;
            redirect_pc    <= mispredict ? correct_pc : '0;
            if (accepted && stat_branches != '1) begin
                stat_branches <= stat_branches + CNT_W'(1);
            end
            if (mispredict && stat_mispredicts != '1) begin
                stat_mispredicts <= stat_mispredicts + CNT_W'(1);
            end
        end
    end

    assign enq_entry = '{pc: ex_pc, target: ex_target, taken: ex_taken};

    btb_update_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UPD_W)
    ) u_upd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accepted),
        .push_data (enq_entry),
        .full      (q_full),
        .out_valid (upd_valid),
        .out_ready (upd_ready),
        .out_data  (head_entry)
    );

    assign upd_pc     = head_entry.pc;
    assign upd_target = head_entry.target;
    assign upd_taken  = head_entry.taken;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - scoreboard bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [31:0]      ex_pc;
    logic             ex_taken;
    logic [31:0]      ex_target;
    logic             ex_pred_taken;
    logic [31:0]      ex_pred_target;
    logic             ex_stall;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             upd_valid;
    logic             upd_ready;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_target;
    logic             upd_taken;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    int n_checks = 0;
    int n_pass   = 0;

    logic [64:0] sb_upd[$];
    logic [31:0] sb_redir[$];

    always #5 clk = ~clk;

    branch_resolve_ctrl #(
        .FIFO_DEPTH   (4),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .ex_stall         (ex_stall),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .upd_taken        (upd_taken),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic issue(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                         input logic pred_taken, input logic [31:0] pred_target);
        @(posedge clk);
        #1;
        ex_valid       = 1'b1;
        ex_is_branch   = 1'b1;
        ex_pc          = pc;
        ex_taken       = taken;
        ex_target      = target;
        ex_pred_taken  = pred_taken;
        ex_pred_target = pred_target;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        ex_valid       = 1'b0;
        ex_is_branch   = 1'b0;
        ex_pc          = '0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_redirect_valid"}, 65'(redirect_valid), 65'd0);
        chk({tag, "_redirect_pc"}, 65'(redirect_pc), 65'd0);
        chk({tag, "_flush"}, 65'(flush), 65'd0);
        chk({tag, "_upd_valid"}, 65'(upd_valid), 65'd0);
        chk({tag, "_upd_entry"}, {upd_pc, upd_target, upd_taken}, 65'd0);
        chk({tag, "_stat_br"}, 65'(stat_branches), 65'd0);
        chk({tag, "_stat_mp"}, 65'(stat_mispredicts), 65'd0);
    endtask

    // Monitor: every handshake and every redirect pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && upd_valid && upd_ready) begin
            if (sb_upd.size() == 0) chk("upd_unexpected", 65'd1, 65'd0);
            else chk("upd_entry", {upd_pc, upd_target, upd_taken}, sb_upd.pop_front());
        end
        if (!rst && redirect_valid) begin
            if (sb_redir.size() == 0) chk("redirect_unexpected", 65'd1, 65'd0);
            else chk("redirect_pc", 65'(redirect_pc), 65'(sb_redir.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        upd_ready = 1'b1;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0;
        ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_stall", 65'(ex_stall), 65'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Correct taken prediction: update one cycle later, no redirect/flush.
        sb_upd.push_back({32'h40, 32'h80, 1'b1});
        issue(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        idle();
        @(negedge clk);
        chk("correct_upd_latency", 65'(upd_valid), 65'd1);
        chk("correct_no_flush", 65'(flush), 65'd0);
        repeat (2) @(negedge clk);
        chk("correct_stat_br", 65'(stat_branches), 65'd1);
        chk("correct_stat_mp", 65'(stat_mispredicts), 65'd0);

        // Direction mispredict, taken: redirect to target, flush for two cycles.
        sb_upd.push_back({32'h100, 32'h200, 1'b1});
        sb_redir.push_back(32'h200);
        issue(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        idle();
        @(negedge clk);
        chk("mp1_flush_c1", 65'(flush), 65'd1);
        chk("mp1_redirect_c1", 65'(redirect_valid), 65'd1);
        @(negedge clk);
        chk("mp1_flush_c2", 65'(flush), 65'd1);
        chk("mp1_redirect_pulse", 65'(redirect_valid), 65'd0);
        @(negedge clk);
        chk("mp1_flush_end", 65'(flush), 65'd0);
        chk("mp1_stat_mp", 65'(stat_mispredicts), 65'd1);
        chk("mp1_stat_br", 65'(stat_branches), 65'd2);

        // Predicted taken, actually not taken: redirect to pc+4.
        sb_upd.push_back({32'h100, 32'h300, 1'b0});
        sb_redir.push_back(32'h104);
        issue(32'h100, 1'b0, 32'h300, 1'b1, 32'h200);
        idle();
        repeat (3) @(posedge clk);

        // Mispredict followed immediately by a branch that must be dropped.
        sb_upd.push_back({32'h500, 32'h600, 1'b1});
        sb_redir.push_back(32'h600);
        issue(32'h500, 1'b1, 32'h600, 1'b0, 32'h0);
        issue(32'h700, 1'b0, 32'h800, 1'b0, 32'h0);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("flush_drop_stat_br", 65'(stat_branches), 65'd4);
        chk("flush_drop_upd_idle", 65'(upd_valid), 65'd0);

        // Fall-through wraps at 2^32.
        sb_upd.push_back({32'hFFFF_FFFC, 32'h10, 1'b0});
        sb_redir.push_back(32'h0);
        issue(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wrap_stat_mp", 65'(stat_mispredicts), 65'd4);

        // Back-pressure: four fill the queue, fifth stalls until a slot frees.
        @(posedge clk); #1 upd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb_upd.push_back({32'h1000 + 32'(i * 16), 32'h1800 + 32'(i), 1'(i % 2)});
            issue(32'h1000 + 32'(i * 16), 1'(i % 2), 32'h1800 + 32'(i), 1'(i % 2), 32'h1800 + 32'(i));
        end
        @(negedge clk);
        chk("full_stall", 65'(ex_stall), 65'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_stall_hold", 65'(ex_stall), 65'd1);
        chk("full_head_stable", {upd_pc, upd_target, upd_taken}, {32'h1000, 32'h1800, 1'b0});
        @(posedge clk); #1 upd_ready = 1'b1;
        @(negedge clk);
        chk("full_stall_on_deq", 65'(ex_stall), 65'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_stall_release", 65'(ex_stall), 65'd0);
        idle();
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("full_stat_br", 65'(stat_branches), 65'd10);
        chk("full_drained", 65'(upd_valid), 65'd0);

        // Reset in the second flush cycle with three entries pending.
        @(posedge clk); #1 upd_ready = 1'b0;
        sb_upd.push_back({32'h2000, 32'h2100, 1'b0});
        sb_upd.push_back({32'h2010, 32'h2100, 1'b0});
        sb_upd.push_back({32'h2020, 32'h3000, 1'b1});
        sb_redir.push_back(32'h3000);
        issue(32'h2000, 1'b0, 32'h2100, 1'b0, 32'h0);
        issue(32'h2010, 1'b0, 32'h2100, 1'b0, 32'h0);
        issue(32'h2020, 1'b1, 32'h3000, 1'b0, 32'h0);
        idle();
        @(posedge clk); #1;
        chk("pre_rst_flush_c2", 65'(flush), 65'd1);
        rst = 1'b1;
        sb_upd.delete();
        @(negedge clk);
        check_reset_outputs("midflush_rst");
        @(posedge clk); #1 rst = 1'b0; upd_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_upd_valid", 65'(upd_valid), 65'd0);
        chk("post_rst_flush", 65'(flush), 65'd0);

        // Statistics saturate at all-ones.
        for (int i = 0; i < 17; i++) begin
            sb_upd.push_back({32'h4000 + 32'(i * 4), 32'h4100, 1'b0});
            issue(32'h4000 + 32'(i * 4), 1'b0, 32'h4100, 1'b0, 32'h0);
        end
        idle();
        repeat (4) @(negedge clk);
        chk("sat_stat_br", 65'(stat_branches), 65'hF);
        chk("sat_stat_mp", 65'(stat_mispredicts), 65'd0);

        chk("sb_upd_empty", 65'(sb_upd.size()), 65'd0);
        chk("sb_redir_empty", 65'(sb_redir.size()), 65'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, BTB update queue entries; power of two, >= 2.
REQ-002 Parameter FLUSH_CYCLES, default 2, cycles flush stays asserted after a mispredict; >= 1.
REQ-003 Parameter CNT_W, default 32, width of statistics counters.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ex_valid  input  1  EX stage holds a valid instruction this cycle.
REQ-007 ex_is_branch  input  1  EX instruction is a conditional branch.
REQ-008 ex_pc  input  32  PC of EX instruction.
REQ-009 ex_taken  input  1  resolved branch outcome.
REQ-010 ex_target  input  32  resolved branch target.
REQ-011 ex_pred_taken  input  1  prediction made at fetch, carried down the pipe.
REQ-012 ex_pred_target  input  32  predicted target carried down the pipe.
REQ-013 ex_stall  output  1  EX must hold its instruction (update queue full).
REQ-014 redirect_valid  output  1  one-cycle pulse: fetch loads redirect_pc.
REQ-015 redirect_pc  output  32  corrected fetch address.
REQ-016 flush  output  1  kill IF/ID contents (wrong-path instructions).
REQ-017 upd_valid  output  1  BTB update request pending.
REQ-018 upd_ready  input  1  BTB accepts update this cycle.
REQ-019 upd_pc, upd_target  output  32 each  branch PC and resolved target for BTB write.
REQ-020 upd_taken  output  1  resolved outcome for BTB state update.
REQ-021 stat_branches, stat_mispredicts  output  CNT_W each  accepted-branch and mispredict counts.

Function
REQ-022 Branch accepted when ex_valid & ex_is_branch & state==IDLE & queue not full; non-branches and branches in FLUSH state are ignored (no update, no count).
REQ-023 ex_stall = ex_valid & ex_is_branch & state==IDLE & queue full, combinational; asserted even if a dequeue occurs that same cycle.
REQ-024 Mispredict = accepted & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target)).
REQ-025 Correct PC = ex_taken ? ex_target : ex_pc + 4, modulo 2^32.
REQ-026 FSM states IDLE, FLUSH; IDLE->FLUSH on mispredict; FLUSH stays FLUSH_CYCLES cycles, then IDLE.
REQ-027 redirect_valid and redirect_pc registered: asserted exactly one cycle, the cycle after the mispredict; redirect_pc holds 0 when redirect_valid low.
REQ-028 flush asserted throughout FLUSH state (FLUSH_CYCLES cycles starting with the redirect cycle).
REQ-029 Every accepted branch (taken or not) enqueues {ex_pc, ex_target, ex_taken}; latency to upd_valid is one cycle if queue was empty.
REQ-030 upd_valid = queue not empty; upd_* show head entry and stay stable while upd_valid & !upd_ready.
REQ-031 Dequeue on upd_valid & upd_ready; simultaneous enqueue and dequeue allowed when not full; occupancy unchanged.
REQ-032 Queue pointers wrap modulo FIFO_DEPTH; order strictly FIFO.
REQ-033 stat_branches increments per accepted branch, stat_mispredicts per mispredict; both saturate at all-ones.

Reset
REQ-034 rst asserted: state=IDLE, queue empty, counters 0, redirect_valid=0, redirect_pc=0, flush=0, upd_valid=0, upd_pc=upd_target=0, upd_taken=0.
REQ-035 rst mid-FLUSH or with pending updates discards them; no redirect or update emitted after release until a new branch resolves.

Structure
REQ-036 Shared package holds FSM state encoding (IDLE, FLUSH) and update-entry field widths (65-bit {pc, target, taken}).
REQ-037 One sub-module, btb_update_fifo (parameterised depth/width, valid/ready output), instantiated once.

Verification
REQ-038 Branch pc=0x100, pred_taken=0, taken=1, target=0x200 -> next cycle redirect_valid=1, redirect_pc=0x200; flush high 2 cycles; stat_mispredicts=1.
REQ-039 Branch pc=0x100, pred_taken=1, pred_target=0x200, taken=0 -> redirect_pc=0x104; upd entry {0x100, target, taken=0}.
REQ-040 Correct prediction pc=0x40, taken=1, target=pred_target=0x80 -> no redirect, no flush; upd_valid next cycle with {0x40,0x80,1}; stat_branches=1.
REQ-041 upd_ready=0, 5 correct branches back-to-back -> 4 queued, ex_stall=1 on 5th; raise upd_ready -> entries drain in order, 5th accepted.
REQ-042 Mispredict then branch in EX next cycle -> second branch ignored (no count, no enqueue) during FLUSH.
REQ-043 rst asserted in 2nd flush cycle with 3 queued entries -> all outputs at reset values, upd_valid=0 after release.
